wb_master: RTL
==============

WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter RETRY_LIMIT, default 3: number of re-issues allowed after wb_rty_i before an error response.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: bus cycles allowed per attempt before abort (used only with WB_MASTER_TIMEOUT_EN).
REQ-003 clk_bus  input  1  bus clock; all state changes on its rising edge.
REQ-004 rst_bus_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  requester offers a transaction.
REQ-006 req_ready  output  1  high only in IDLE; the request is accepted when req_valid and req_ready are both high.
REQ-007 req_adr / req_dat  input  32 / 32  address and write data.
REQ-008 req_sel  input  4  byte enables.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes the response.
REQ-012 rsp_dat  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  error response: err, retry exhaustion, or timeout.
REQ-014 rsp_timeout  output  1  error was caused by timeout.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone pipelined master controls.
REQ-016 wb_adr_o / wb_dat_o  output  32 / 32  bus address and write data.
REQ-017 wb_sel_o  output  4  bus byte selects.
REQ-018 wb_dat_i  input  32  slave read data.
REQ-019 wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  input  1 each  slave termination and stall inputs.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, RESP. Only one transaction is outstanding at a time.
REQ-021 IDLE: on acceptance, register adr/dat/sel/we, clear retry and timeout counters, and go to REQ on the next edge.
REQ-022 REQ: wb_cyc_o=1 and wb_stb_o=1. If wb_stall_i=0, go to WAIT; otherwise hold stb and all bus outputs stable.
REQ-023 WAIT: wb_cyc_o=1 and wb_stb_o=0. Wait for a termination input.
REQ-024 Termination is sampled in both REQ and WAIT. Priority is err > ack > rty. A termination coinciding with stb acceptance is honoured in that cycle.
REQ-025 On ack: capture wb_dat_i (read) or 0 (write), set rsp_err=0, drop cyc, go to RESP. Latency with a zero-wait slave: acceptance to rsp_valid is 2 cycles.
REQ-026 On err: set rsp_dat=0, rsp_err=1, go to RESP.
REQ-027 On rty: if retry count < RETRY_LIMIT, increment it, drop cyc for exactly one cycle in IDLE-like gap state handling (cyc=0), then return to REQ. Otherwise respond with rsp_err=1.
REQ-028 RESP: rsp_valid=1 and wb_cyc_o=0. Response fields are held stable until rsp_ready; then go to IDLE. req_ready stays 0 in RESP, so a new request cannot be accepted in the same cycle.
REQ-029 wb_cyc_o and wb_stb_o are never high outside REQ/WAIT. wb_stb_o is never high when wb_cyc_o is low.
REQ-030 Terminations received in IDLE or RESP are ignored.

Reset
REQ-031 When rst_bus_n=0: state=IDLE; wb_cyc_o, wb_stb_o, wb_we_o=0; wb_adr_o, wb_dat_o, wb_sel_o=0; rsp_valid, rsp_err, rsp_timeout=0; rsp_dat=0; counters=0. This takes effect immediately, without a clock.
REQ-032 Reset asserted mid-transaction abandons it: cyc drops asynchronously and no response is produced.

Configuration
REQ-033 With macro WB_MASTER_TIMEOUT_EN defined: a per-attempt counter runs in REQ and WAIT. When it reaches TIMEOUT_CYCLES with no termination, cyc drops and the block goes to RESP with rsp_err=1 and rsp_timeout=1. The counter restarts on each retry.
REQ-034 Without WB_MASTER_TIMEOUT_EN: no counter is built, the block waits indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-035 Read 0x80000010 with zero-wait ack and wb_dat_i=0xDEADBEEF -> rsp_valid 2 cycles after acceptance, rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-036 Write 0x00000004, data 0x12345678, sel=4'b0011, wb_stall_i high 3 cycles -> stb held with adr/dat/sel stable for 4 cycles, single ack, rsp_dat=0.
REQ-037 Slave answers rty 3 times then ack -> 4 stb acceptances with a cyc=0 gap between each, rsp_err=0; with 4 rty -> rsp_err=1 after the 4th.
REQ-038 err and ack asserted in the same cycle -> rsp_err=1, rsp_dat=0.
REQ-039 With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave silent -> cyc drops after 8 cycles, rsp_err=1, rsp_timeout=1.
REQ-040 rst_bus_n pulled low during WAIT with rsp_ready=0 for 5 cycles -> cyc=0 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/wb_master.sv
// Single-outstanding Wishbone pipelined master with retry handling and a request/response front end.
// Optional per-attempt bus timeout is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master #(
  parameter int RETRY_LIMIT    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_bus,
  input  logic        rst_bus_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  input  logic        req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        wb_stall_i
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  localparam int RW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

  logic [2:0]    state_r, state_s;
  logic          cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
  logic [31:0]   adr_r, adr_s, dat_r, dat_s;
  logic [3:0]    sel_r, sel_s;
  logic [RW-1:0] retry_r, retry_s;
  logic          req_ready_r, req_ready_s;
  logic          rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s, rsp_to_r, rsp_to_s;
  logic [31:0]   rsp_dat_r, rsp_dat_s;
  logic          in_bus_s;
  logic          to_hit_s;

  assign in_bus_s = (state_r == ST_REQ) || (state_r == ST_WAIT);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_r;

  // Per-attempt cycle counter; cleared whenever no bus cycle is in flight, so each retry restarts it.
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      to_cnt_r <= '0;
    end else if (in_bus_s) begin
      to_cnt_r <= to_cnt_r + TW'(1'b1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign to_hit_s = in_bus_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: the parameter has no effect and this folds to zero.
  assign to_hit_s = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    sel_s       = sel_r;
    retry_s     = retry_r;
    req_ready_s = req_ready_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_to_s    = rsp_to_r;
    rsp_dat_s   = rsp_dat_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          adr_s       = req_adr;
          dat_s       = req_dat;
          sel_s       = req_sel;
          we_s        = req_we;
          retry_s     = '0;
          cyc_s       = 1'b1;
          stb_s       = 1'b1;
          req_ready_s = 1'b0;
          state_s     = ST_REQ;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ST_REQ, ST_WAIT: begin
        // Terminations are honoured even in the cycle stb is accepted; err outranks ack outranks rty.
        if (wb_err_i || wb_ack_i || to_hit_s || (wb_rty_i && int'(retry_r) >= RETRY_LIMIT)) begin
          state_s     = ST_RESP;
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = wb_err_i || !wb_ack_i;
          rsp_to_s    = to_hit_s && !wb_err_i && !wb_ack_i && !wb_rty_i;
          rsp_dat_s   = (wb_ack_i && !wb_err_i && !we_r) ? wb_dat_i : 32'h0000_0000;
        end else if (wb_rty_i) begin
          retry_s = retry_r + RW'(1'b1);
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          state_s = ST_GAP;
        end else if ((state_r == ST_REQ) && !wb_stall_i) begin
          stb_s   = 1'b0;
          state_s = ST_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      ST_GAP: begin
        cyc_s   = 1'b1;
        stb_s   = 1'b1;
        state_s = ST_REQ;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_to_s    = 1'b0;
          rsp_dat_s   = 32'h0000_0000;
          req_ready_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        retry_s     = '0;
        req_ready_s = 1'b1;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_to_s    = 1'b0;
        rsp_dat_s   = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers; reset clears the bus cycle immediately and drops any pending response.
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      state_r     <= ST_IDLE;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      sel_r       <= 4'h0;
      retry_r     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_to_r    <= 1'b0;
      rsp_dat_r   <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      sel_r       <= sel_s;
      retry_r     <= retry_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_to_r    <= rsp_to_s;
      rsp_dat_r   <= rsp_dat_s;
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_to_r;
  assign rsp_dat     = rsp_dat_r;
  assign wb_cyc_o    = cyc_r;
  assign wb_stb_o    = stb_r;
  assign wb_we_o     = we_r;
  assign wb_adr_o    = adr_r;
  assign wb_dat_o    = dat_r;
  assign wb_sel_o    = sel_r;

endmodule
